uart_rx: RTL and testbench

//   UART receiver; the receive-side counterpart of the team's UART transmitter (1 start 0, DATA_WIDTH bits LSB first,

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop checking
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int ECW = $clog2(OVERSAMPLE);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [ECW-1:0] EC_LAST = ECW'(OVERSAMPLE - 1);
    localparam logic [ECW-1:0] EC_S0   = ECW'(M - 1);
    localparam logic [ECW-1:0] EC_S1   = ECW'(M);
    localparam logic [ECW-1:0] EC_S2   = ECW'(M + 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    rx_meta_q;
    logic                    rx_s_q;
    logic [ECW-1:0]          ec_q;
    logic [BCW-1:0]          bc_q;
    logic [1:0]              samp_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_bad_q;
    logic                    valid_q;
    logic                    par_err_q;
    logic                    stp_err_q;
    logic                    busy_q;
    logic                    vote_d;
    logic                    exp_par_d;

    // Third sample is taken live at ec=M+1, so the vote is ready in that same cycle.
    assign vote_d    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign exp_par_d = par_typ_q ? ~^shift_q : ^shift_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            ec_q      <= '0;
            bc_q      <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (!rx_s_q) begin
                    state_q   <= START;
                    ec_q      <= ECW'(1);
                    bc_q      <= '0;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_bad_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
            end else begin
                ec_q <= (ec_q == EC_LAST) ? '0 : ec_q + ECW'(1);
                if (ec_q == EC_S0) samp_q[0] <= rx_s_q;
                if (ec_q == EC_S1) samp_q[1] <= rx_s_q;
                case (state_q)
                    START: begin
                        if (ec_q == EC_S2 && vote_d) begin
                            state_q <= IDLE;
                            ec_q    <= '0;
                            busy_q  <= 1'b0;
                        end else if (ec_q == EC_LAST) begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (ec_q == EC_S2) shift_q <= {vote_d, shift_q[DATA_WIDTH-1:1]};
                        if (ec_q == EC_LAST) begin
                            if (bc_q == BC_LAST) state_q <= par_en_q ? PARITY : STOP;
                            else                 bc_q    <= bc_q + BCW'(1);
                        end
                    end
                    PARITY: begin
                        if (ec_q == EC_S2)   par_bad_q <= (vote_d != exp_par_d);
                        if (ec_q == EC_LAST) state_q   <= STOP;
                    end
                    STOP: begin
                        // Leave at mid stop bit so a start edge right after the stop bit is caught.
                        if (ec_q == EC_S2) begin
                            state_q <= IDLE;
                            ec_q    <= '0;
                            busy_q  <= 1'b0;
                            if (!vote_d)        stp_err_q <= 1'b1;
                            else if (par_bad_q) par_err_q <= 1'b1;
                            else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    localparam int W  = 8;
    localparam int OS = 8;
    localparam int M  = OS / 2;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         RX_IN = 1'b1;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_ERR;
    logic         STP_ERR;
    logic         Busy;

    uart_rx #(.DATA_WIDTH(W), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .rst_n(rst_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 1 = DATA_VALID, 2 = PAR_ERR, 4 = STP_ERR
    typedef struct {
        int           kind;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          obs_q[$];
    logic [W-1:0] model_pdata = '0;

    always @(negedge CLK) begin
        ev_t e;
        if (rst_n && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            e.kind = int'({STP_ERR, PAR_ERR, DATA_VALID});
            e.data = P_DATA;
            e.cyc  = cyc;
            obs_q.push_back(e);
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting just after a clock edge. abort_at >= 0 stops driving after that
    // many cycles and records no expectation.
    task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt, input bit flip_par,
                              input bit bad_stop, input int glitch_bit, input int abort_at);
        logic [W+2:0] line;
        int           n;
        int           c0;
        int           k;
        ev_t          e;
        line    = '1;
        line[0] = 1'b0;
        for (int i = 0; i < W; i++) line[1+i] = d[i];
        n = 1 + W;
        if (pe) begin
            line[n] = (pt ? ~^d : ^d) ^ flip_par;
            n++;
        end
        line[n] = ~bad_stop;
        n++;
        PAR_EN  = pe;
        PAR_TYP = pt;
        c0 = cyc;
        k  = 0;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < OS; j++) begin
                if (abort_at >= 0 && k == abort_at) return;
                RX_IN = line[b] ^ (b == glitch_bit && j == M);
                if (b == 1 && j == 0) begin
                    PAR_EN  = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                end
                if (b == 3 && j == 0) check("busy_mid", 32'(Busy), 32'd1);
                @(posedge CLK);
                #1;
                k++;
            end
        end
        RX_IN = 1'b1;
        e.kind = bad_stop ? 4 : ((pe && flip_par) ? 2 : 1);
        e.data = (e.kind == 1) ? d : model_pdata;
        if (e.kind == 1) model_pdata = d;
        // pulse lands M+2 cycles into the stop bit, plus 2 cycles of input synchroniser
        e.cyc = c0 + (1 + W + (pe ? 1 : 0)) * OS + M + 2 + 2;
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            check({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
            check({tag, "_cycle"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_busy_idle"}, 32'(Busy), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out"}, {20'd0, P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy}, 32'd0);
    endtask

    logic [W-1:0] b2b [3];

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(2 * OS);
        compare_events("t1");

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(OS);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(2 * OS);
        compare_events("t2");
        check("t2_pdata", 32'(P_DATA), 32'h3C);

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2 * OS);
        compare_events("t3");

        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        idle(2 * OS);
        compare_events("t4_glitch");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(2 * OS);
        compare_events("t4");

        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h55;
        for (int f = 0; f < 3; f++)
            send_frame(b2b[f], 1'b1, 1'b1, 1'b0, 1'b0, $urandom_range(0, W + 2), -1);
        idle(2 * OS);
        compare_events("t5");

        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1, (1 + 4) * OS + M);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_reset");
        model_pdata = '0;
        @(posedge CLK);
        #1;
        RX_IN = 1'b1;
        rst_n = 1'b1;
        idle(2 * OS);
        compare_events("t6_quiet");
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(2 * OS);
        compare_events("t6");

        for (int f = 0; f < 30; f++) begin
            bit pe, bad;
            pe  = 1'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(8'($urandom), pe, 1'($urandom), ($urandom_range(0, 3) == 0), bad,
                       ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, W + 2), -1);
            idle(bad ? 2 * OS : $urandom_range(0, OS));
        end
        idle(2 * OS);
        compare_events("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
